// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB completer memory.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    // Number of byte strobes for a given data width.
    function automatic int APB_STRB_W(input int data_width);
        return data_width / 8;
    endfunction

    // Word index of a byte address relative to the array base.
    // A wrapped result (addr < base) is harmless: callers flag that case separately.
    function automatic logic [63:0] word_index(input logic [63:0] addr,
                                               input logic [63:0] base,
                                               input int          bytes_per_word);
        return (addr - base) >> $clog2(bytes_per_word);
    endfunction

endpackage

// File: rtl/apb_byte_mem.sv
// Register-array memory with per-byte write enables and a combinational read port.
module apb_byte_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int IDX_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Byte-lane writes; whole array cleared on reset.
    // NOTE: clearing a memory in reset forces it into flops (no RAM macro); intended here,
    // since every word must read as zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer: IDLE/ACCESS FSM, wait-state counter and address error decode
// in front of a byte-enabled register array.
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int                ADDR_WIDTH  = 32,
    parameter int                DATA_WIDTH  = 32,
    parameter int                DEPTH       = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int                WAIT_STATES = 2
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);

    localparam int         STRB_W     = APB_STRB_W(DATA_WIDTH);
    localparam int         BYTE_SHIFT = $clog2(STRB_W);
    localparam int         IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WS         = 4'(WAIT_STATES);

    apb_state_e            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic                  write_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     strb_q;
    logic [DATA_WIDTH-1:0] prdata_q;

    logic [63:0]           idx_full;
    logic [IDX_W-1:0]      idx_now, rd_idx;
    logic                  err_now, rd_err, rd_write;
    logic                  setup, done, enter_done;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Error decode on the live setup address.
    assign idx_full = word_index(64'(PADDR), 64'(BASE_ADDR), STRB_W);
    assign idx_now  = idx_full[IDX_W-1:0];
    assign err_now  = (|PADDR[BYTE_SHIFT-1:0]) || (PADDR < BASE_ADDR) || (idx_full >= 64'(DEPTH));

    assign setup = (state_q == IDLE) && PSEL && !PENABLE;
    assign done  = (state_q == ACCESS) && (cnt_q == 4'd0);

    // The edge entering completion is either the setup edge (no wait states) or
    // the last wait-state edge; the read port must see the matching address.
    assign enter_done = (setup && (WS == 4'd0)) ||
                        ((state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd1));
    assign rd_idx   = (state_q == IDLE) ? idx_now : idx_q;
    assign rd_err   = (state_q == IDLE) ? err_now : err_q;
    assign rd_write = (state_q == IDLE) ? PWRITE  : write_q;

    // Next-state and counter logic.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = ACCESS;
                    cnt_d   = WS;
                end
            end
            ACCESS: begin
                if (done) begin
                    state_d = IDLE;
                end else if (!PSEL) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (PENABLE) begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, counter, setup capture and registered read data.
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            prdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (setup) begin
                idx_q   <= idx_now;
                write_q <= PWRITE;
                err_q   <= err_now;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
            end
            if (enter_done && (!rd_write || rd_err)) begin
                prdata_q <= rd_err ? '0 : mem_rdata;
            end
        end
    end

    apb_byte_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk   (PCLK),
        .rst_n (PRESETn),
        .we    (done && write_q && !err_q),
        .waddr (idx_q),
        .wdata (wdata_q),
        .wstrb (strb_q),
        .raddr (rd_idx),
        .rdata (mem_rdata)
    );

    assign PREADY  = done;
    assign PSLVERR = done ? err_q : APB_OKAY;
    assign PRDATA  = prdata_q;

endmodule
